uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive half of the UART peripheral; peer of uart_tx with the same runtime framing config.
//  Oversamples the async rx line, frames start/data/parity/stop, and pushes each byte into the RX FIFO.
//  Reports parity, framing and overrun errors alongside the FIFO write strobe.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per bit period (100 MHz / 115200); must be >= 4
// PORTS
//  clk            in   1  system clock; all logic on posedge
//  rst            in   1  reset, asynchronous, active-high
//  rx             in   1  serial line, async to clk, idle high
//  rx_data        out  8  received byte, LSB-first, zero-extended above num_data_bits
//  rx_wren        out  1  one-cycle FIFO write strobe; rx_data valid this cycle
//  rx_full        in   1  RX FIFO full; write suppressed when high
//  rx_busy        out  1  high from start-bit confirm until frame end
//  parity_err     out  1  one-cycle pulse: parity mismatch on completed frame
//  frame_err      out  1  one-cycle pulse: any stop bit sampled low
//  overrun_err    out  1  one-cycle pulse: frame completed while rx_full high
//  num_data_bits  in   4  data bits per frame; legal 5..8, <5 clamps to 5, >8 clamps to 8
//  stop_bits      in   stop_bits_t  STOP_BITS_1 / STOP_BITS_2
//  parity         in   parity_t     PARITY_NONE / PARITY_EVEN / PARITY_ODD
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, synchronizer flops 1; reset mid-frame aborts with no strobe.
//  - rx passes through a 2-FF synchronizer (2-cycle input latency) before any use.
//  - num_data_bits/stop_bits/parity are captured at start-bit confirm; changes mid-frame are ignored.
//  - FSM:
//    IDLE:      on synced rx 1->0, clear bit-timer, go to START.
//    START:     at CLKS_PER_BIT/2, resample.
//               Low -> confirm, raise rx_busy, go to DATA.
//               High -> glitch, back to IDLE with no outputs.
//    DATA:      sample every CLKS_PER_BIT (mid-bit); shift in LSB-first.
//               After N bits -> PARITY if enabled, else STOP.
//    PARITY:    sample one bit.
//               EVEN: error if XOR(data, parity bit) = 1.
//               ODD: error if XOR(data, parity bit) = 0.
//    STOP:      sample 1 or 2 stop bits; any low sets the frame error.
//               After the last stop-bit sample -> DONE.
//    DONE:      one cycle. If !rx_full: rx_wren=1 and update rx_data.
//               If rx_full: no write, rx_data unchanged, overrun_err=1.
//               parity_err/frame_err pulse in this same cycle, regardless of rx_full.
//               Go to IDLE, or to WAIT_IDLE if frame_err.
//    WAIT_IDLE: after a framing error (incl. break), hold until synced rx=1, then IDLE.
//               Prevents re-triggering on a held-low line.
//  - Errored frames are still written (data + error pulse), so software can drop them.
//  - rx_busy falls in DONE.
//  - Latency: rx_wren is exactly 1 cycle after the final stop-bit mid-sample.
//  - Back-to-back frames: a start edge arriving in the DONE cycle is not lost.
//    IDLE edge detect uses the registered previous sample.
//  - Bit timer width: $clog2(CLKS_PER_BIT); wraps at CLKS_PER_BIT-1 and never overflows.
//  - Bit counter is 4 bits and counts to the clamped N.
// STRUCTURE
//  - uart_pkg: stop_bits_t and parity_t (shared with uart_tx).
//    Add uart_rx_state_t enum {IDLE, START, DATA, PARITY, STOP, DONE, WAIT_IDLE}.
//  - Single module; synchronizer, bit timer and shift register are inline. No sub-module.
// TESTING  (CLKS_PER_BIT=16; bench drives rx from a behavioural serializer)
//  1. 0x2B, 8N1 -> one rx_wren, rx_data=0x2B, all error pulses 0, rx_busy low afterwards.
//  2. 0x53 8N2, then 0x71 8E1 with correct parity, back-to-back (no idle gap)
//     -> two strobes: 0x53, 0x71; no errors.
//  3. 0x71 with PARITY_ODD but even parity bit sent -> rx_wren with rx_data=0x71, parity_err=1 same cycle.
//  4. num_data_bits=7, 0x55 7N1 -> rx_data=0x55 (bit7=0).
//     num_data_bits=3 -> frame decoded as 5 bits.
//  5. Stop bit driven low, then rx held low 30 bits (break) -> one strobe with frame_err=1 and rx_data=0x00.
//     No further strobes until rx returns high.
//  6. rx glitch low for 6 clks -> no strobe, rx_busy stays 0.
//     rx_full=1 during 0x2B -> no rx_wren, overrun_err=1.
//     rst asserted mid-DATA -> outputs 0, next frame received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: runtime framing config (common with uart_tx) and the receiver FSM state.
package uart_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BIT_CNT_W = 4;

  typedef enum logic {
    STOP_BITS_1 = 1'b0,
    STOP_BITS_2 = 1'b1
  } stop_bits_t;

  typedef enum logic [1:0] {
    PARITY_NONE = 2'd0,
    PARITY_EVEN = 2'd1,
    PARITY_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    DONE      = 3'd5,
    WAIT_IDLE = 3'd6
  } uart_rx_state_t;

  // Data-bit count limited to the legal 5..8 range.
  function automatic logic [BIT_CNT_W-1:0] clamp_data_bits(input logic [BIT_CNT_W-1:0] n);
    if (n < BIT_CNT_W'(5)) begin
      return BIT_CNT_W'(5);
    end else if (n > BIT_CNT_W'(8)) begin
      return BIT_CNT_W'(8);
    end else begin
      return n;
    end
  endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, frames start/data/parity/stop at mid-bit, writes bytes to the RX FIFO.
// Ports:
//   clk, rst          clock, async active-high reset
//   rx                async serial line, idle high
//   rx_data/rx_wren   received byte and one-cycle FIFO write strobe
//   rx_full           FIFO full; suppresses the write and flags overrun
//   rx_busy           high from start-bit confirm until frame end
//   parity_err, frame_err, overrun_err   one-cycle error pulses, aligned with the frame-end cycle
//   num_data_bits, stop_bits, parity     framing config, captured at start-bit confirm
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_W-1:0]    rx_data,
  output logic                 rx_wren,
  input  logic                 rx_full,
  output logic                 rx_busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  input  logic [BIT_CNT_W-1:0] num_data_bits,
  input  stop_bits_t           stop_bits,
  input  parity_t              parity
);

  localparam int unsigned TIMER_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

  // Synchronizer and edge-detect history.
  logic rx_meta, rx_sync, rx_prev;
  logic fall;

  uart_rx_state_t state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [BIT_CNT_W-1:0] nbits_q, nbits_d;
  stop_bits_t           stop2_q, stop2_d;
  parity_t              parity_q, parity_d;

  logic [DATA_W-1:0] rx_data_d;
  logic rx_wren_d, rx_busy_d, parity_err_d, frame_err_d, overrun_err_d;
  logic tick_half, tick_full, stop_err_new;

  assign fall      = rx_prev & ~rx_sync;
  assign tick_half = (timer_q == TIMER_W'(HALF_BIT - 1));
  assign tick_full = (timer_q == TIMER_W'(CLKS_PER_BIT - 1));
  assign stop_err_new = stop_err_q | ~rx_sync;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d       = state_q;
    timer_d       = tick_full ? '0 : timer_q + TIMER_W'(1);
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    par_acc_d     = par_acc_q;
    par_err_d     = par_err_q;
    stop_err_d    = stop_err_q;
    stop_cnt_d    = stop_cnt_q;
    nbits_d       = nbits_q;
    stop2_d       = stop2_q;
    parity_d      = parity_q;
    rx_data_d     = rx_data;
    rx_wren_d     = 1'b0;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (tick_half) begin
          timer_d = '0;
          if (!rx_sync) begin
            state_d    = DATA;
            nbits_d    = clamp_data_bits(num_data_bits);
            stop2_d    = stop_bits;
            parity_d   = parity;
            bit_cnt_d  = '0;
            shift_d    = '0;
            par_acc_d  = 1'b0;
            par_err_d  = 1'b0;
            stop_err_d = 1'b0;
            stop_cnt_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_full) begin
          shift_d[bit_cnt_q[2:0]] = rx_sync;
          par_acc_d = par_acc_q ^ rx_sync;
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == nbits_q - BIT_CNT_W'(1)) begin
            state_d = (parity_q != PARITY_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        // Even: data^bit must be 0; odd: must be 1.
        if (tick_full) begin
          par_err_d = par_acc_q ^ rx_sync ^ (parity_q == PARITY_ODD);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick_full) begin
          stop_err_d = stop_err_new;
          if (stop2_q == STOP_BITS_2 && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            // Outputs are registered here so they are visible during the DONE cycle.
            state_d       = DONE;
            rx_wren_d     = ~rx_full;
            overrun_err_d = rx_full;
            rx_data_d     = rx_full ? rx_data : shift_q;
            parity_err_d  = par_err_q;
            frame_err_d   = stop_err_new;
          end
        end
      end
      DONE: begin
        timer_d = '0;
        if (stop_err_q)  state_d = WAIT_IDLE;
        else if (fall)   state_d = START;
        else             state_d = IDLE;
      end
      WAIT_IDLE: begin
        timer_d = '0;
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d == DATA) || (state_d == PARITY) || (state_d == STOP);
  end

  // All state and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_sync     <= 1'b1;
      rx_prev     <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_acc_q   <= 1'b0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      stop_cnt_q  <= 1'b0;
      nbits_q     <= BIT_CNT_W'(8);
      stop2_q     <= STOP_BITS_1;
      parity_q    <= PARITY_NONE;
      rx_data     <= '0;
      rx_wren     <= 1'b0;
      rx_busy     <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rx_sync     <= rx_meta;
      rx_prev     <= rx_sync;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_acc_q   <= par_acc_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
      stop_cnt_q  <= stop_cnt_d;
      nbits_q     <= nbits_d;
      stop2_q     <= stop2_d;
      parity_q    <= parity_d;
      rx_data     <= rx_data_d;
      rx_wren     <= rx_wren_d;
      rx_busy     <= rx_busy_d;
      parity_err  <= parity_err_d;
      frame_err   <= frame_err_d;
      overrun_err <= overrun_err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a behavioural serializer drives rx, expected frames go into a queue,
// and a monitor pops and compares whenever the receiver presents a strobe or error pulse.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 16;

  typedef struct packed {
    logic       wren;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_wren;
  logic       rx_full = 1'b0;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic [3:0] num_data_bits = 4'd8;
  stop_bits_t stop_bits = STOP_BITS_1;
  parity_t    parity = PARITY_NONE;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_wren(rx_wren),
    .rx_full(rx_full), .rx_busy(rx_busy), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err),
    .num_data_bits(num_data_bits), .stop_bits(stop_bits), .parity(parity)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: any strobe or error pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (rx_wren || parity_err || frame_err || overrun_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: wren=%0b data=%0h perr=%0b ferr=%0b ovr=%0b",
                 rx_wren, rx_data, parity_err, frame_err, overrun_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rx_wren", 32'(rx_wren), 32'(e.wren));
        chk("rx_data", 32'(rx_data), 32'(e.data));
        chk("parity_err", 32'(parity_err), 32'(e.perr));
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        chk("overrun_err", 32'(overrun_err), 32'(e.ovr));
      end
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // pmode: 0 none, 1 even, 2 odd. flip_par sends the wrong parity bit.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit two_stop,
                            input int pmode, input bit flip_par, input bit stop_low);
    logic p;
    send_bit(1'b0);
    for (int i = 0; i < nb; i++) send_bit(d[i]);
    if (pmode != 0) begin
      p = 1'b0;
      for (int i = 0; i < nb; i++) p = p ^ d[i];
      if (pmode == 2) p = ~p;
      if (flip_par) p = ~p;
      send_bit(p);
    end
    send_bit(~stop_low);
    if (two_stop) send_bit(1'b1);
  endtask

  task automatic push(input logic w, input logic [7:0] d, input logic pe, input logic fe, input logic ov);
    exp_t e;
    e.wren = w; e.data = d; e.perr = pe; e.ferr = fe; e.ovr = ov;
    exp_q.push_back(e);
  endtask

  // Bounded wait for the scoreboard to drain.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
    repeat (CPB) @(negedge clk);
    chk({name, "_busy_low"}, 32'(rx_busy), 32'd0);
  endtask

  initial begin
    bit busy_seen;
    repeat (3) @(negedge clk);
    chk("reset_data", 32'(rx_data), 32'h00);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    chk("reset_pulses", 32'({rx_wren, parity_err, frame_err, overrun_err}), 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // 0x2B 8N1
    push(1'b1, 8'h2B, 1'b0, 1'b0, 1'b0);
    send_frame(8'h2B, 8, 1'b0, 0, 1'b0, 1'b0);
    drain("t1_8n1");

    // 0x53 8N2 then 0x71 8E1 back-to-back
    stop_bits = STOP_BITS_2;
    push(1'b1, 8'h53, 1'b0, 1'b0, 1'b0);
    push(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    send_frame(8'h53, 8, 1'b1, 0, 1'b0, 1'b0);
    stop_bits = STOP_BITS_1;
    parity = PARITY_EVEN;
    send_frame(8'h71, 8, 1'b0, 1, 1'b0, 1'b0);
    drain("t2_b2b");

    // 0x71 odd parity configured, even parity bit sent
    parity = PARITY_ODD;
    push(1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
    send_frame(8'h71, 8, 1'b0, 2, 1'b1, 1'b0);
    drain("t3_par_err");
    parity = PARITY_NONE;

    // 7 data bits: bit7 of 0xD5 never sent, result 0x55
    num_data_bits = 4'd7;
    push(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    send_frame(8'hD5, 7, 1'b0, 0, 1'b0, 1'b0);
    drain("t4_7bit");

    // num_data_bits=3 clamps to 5: 5 bits of 0x35 give 0x15
    num_data_bits = 4'd3;
    push(1'b1, 8'h15, 1'b0, 1'b0, 1'b0);
    send_frame(8'h35, 5, 1'b0, 0, 1'b0, 1'b0);
    drain("t4_clamp5");
    num_data_bits = 4'd8;

    // Break: line low 30 bit times, one errored frame of zeros, then silence
    push(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clk);
    rx = 1'b1;
    drain("t5_break");

    // Short glitch: no confirm, busy never rises
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    chk("t6_glitch_busy", 32'(busy_seen), 32'd0);

    // Overrun: no write, rx_data holds the last written byte (break frame 0x00)
    rx_full = 1'b1;
    push(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'h2B, 8, 1'b0, 0, 1'b0, 1'b0);
    drain("t6_overrun");
    rx_full = 1'b0;

    // Reset mid-DATA, then a clean frame
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_data", 32'(rx_data), 32'h00);
    chk("t6_rst_busy", 32'(rx_busy), 32'd0);
    chk("t6_rst_pulses", 32'({rx_wren, parity_err, frame_err, overrun_err}), 32'd0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    push(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b0, 0, 1'b0, 1'b0);
    drain("t6_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
